// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU
// between two valid/ready requesters, with registered operands/result.
module alu_share_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_OpCode,
  input  logic [5:0]       req0_Funct,
  input  logic [31:0]      req0_in1,
  input  logic [31:0]      req0_in2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_OpCode,
  input  logic [5:0]       req1_Funct,
  input  logic [31:0]      req1_in1,
  input  logic [31:0]      req1_in2,
  output logic [5:0]       alu_OpCode,
  output logic [5:0]       alu_Funct,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_out,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0] state;
  logic       last_grant;
  logic       gnt0;
  logic       gnt1;

  // Grant one port in IDLE; on contention favour the port not served last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  // Operation sequencer: latch operands, capture result, hold until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_OpCode <= '0;
      alu_Funct  <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      rsp_out    <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            alu_OpCode <= req0_OpCode;
            alu_Funct  <= req0_Funct;
            alu_in1    <= req0_in1;
            alu_in2    <= req0_in2;
            rsp_id     <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (gnt1) begin
            alu_OpCode <= req1_OpCode;
            alu_Funct  <= req1_Funct;
            alu_in1    <= req1_in1;
            alu_in2    <= req1_in2;
            rsp_id     <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_out  <= alu_out;
          rsp_zero <= alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (rsp_id) begin
              if (cnt1 != CNT_MAX) cnt1 <= cnt1 + CNT_ONE;
            end else begin
              if (cnt0 != CNT_MAX) cnt0 <= cnt0 + CNT_ONE;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a behavioural ALU model
// attached; a second CNT_W=2 instance checks counter saturation.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [5:0]  req0_OpCode, req0_Funct, req1_OpCode, req1_Funct;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, busy;
  logic [5:0]  alu_OpCode, alu_Funct;
  logic [31:0] alu_in1, alu_in2, alu_out, rsp_out;
  logic        alu_zero;
  logic [15:0] cnt0, cnt1;

  logic        d2_req0_ready, d2_req1_ready, d2_rsp_valid, d2_rsp_id;
  logic        d2_rsp_zero, d2_busy, d2_alu_zero;
  logic [5:0]  d2_alu_OpCode, d2_alu_Funct;
  logic [31:0] d2_alu_in1, d2_alu_in2, d2_alu_out, d2_rsp_out;
  logic [1:0]  d2_cnt0, d2_cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] alu_f(input logic [5:0] op,
                                        input logic [5:0] fn,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (op == 6'd4) r = a - b;
    else if (op == 6'd0) begin
      case (fn)
        6'd32, 6'd33: r = a + b;
        6'd34, 6'd35: r = a - b;
        6'd36:        r = a & b;
        6'd37:        r = a | b;
        default:      r = '0;
      endcase
    end
    return r;
  endfunction

  assign alu_out     = alu_f(alu_OpCode, alu_Funct, alu_in1, alu_in2);
  assign alu_zero    = (alu_out == 32'd0);
  assign d2_alu_out  = alu_f(d2_alu_OpCode, d2_alu_Funct, d2_alu_in1, d2_alu_in2);
  assign d2_alu_zero = (d2_alu_out == 32'd0);

  alu_share_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_OpCode(req0_OpCode), .req0_Funct(req0_Funct),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_OpCode(req1_OpCode), .req1_Funct(req1_Funct),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .alu_OpCode(alu_OpCode), .alu_Funct(alu_Funct),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .busy(busy),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  alu_share_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(d2_req0_ready),
    .req0_OpCode(req0_OpCode), .req0_Funct(req0_Funct),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(d2_req1_ready),
    .req1_OpCode(req1_OpCode), .req1_Funct(req1_Funct),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .alu_OpCode(d2_alu_OpCode), .alu_Funct(d2_alu_Funct),
    .alu_in1(d2_alu_in1), .alu_in2(d2_alu_in2),
    .alu_out(d2_alu_out), .alu_zero(d2_alu_zero),
    .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d2_rsp_id),
    .rsp_out(d2_rsp_out), .rsp_zero(d2_rsp_zero), .busy(d2_busy),
    .cnt0(d2_cnt0), .cnt1(d2_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit p, input logic [5:0] op,
                         input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b);
    if (p) begin
      req1_valid = 1'b1; req1_OpCode = op; req1_Funct = fn;
      req1_in1 = a; req1_in2 = b;
    end else begin
      req0_valid = 1'b1; req0_OpCode = op; req0_Funct = fn;
      req0_in1 = a; req0_in2 = b;
    end
  endtask

  // One full operation with rsp_ready high; starts and ends on a negedge in IDLE
  task automatic run_op(input string tag, input bit p,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic ez);
    rsp_ready = 1'b1;
    set_req(p, op, fn, a, b);
    #1;
    chk({tag, "_ready"}, p ? req1_ready : req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_in1"}, alu_in1, a);
    chk({tag, "_vld_exec"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_vld"}, rsp_valid, 1'b1);
    chk({tag, "_out"}, rsp_out, eo);
    chk({tag, "_zero"}, rsp_zero, ez);
    chk({tag, "_id"}, rsp_id, p);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 0; req0_OpCode = 0; req0_Funct = 0; req0_in1 = 0; req0_in2 = 0;
    req1_valid = 0; req1_OpCode = 0; req1_Funct = 0; req1_in1 = 0; req1_in2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vld", rsp_valid, 1'b0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_cnt0", cnt0, 32'd0);
    chk("rst_cnt1", cnt1, 32'd0);
    reset = 1'b0;

    run_op("add", 1'b0, 6'd0, 6'd32, 32'hFFFFFFE3, 32'd11, 32'hFFFFFFEE, 1'b0);
    chk("add_cnt0", cnt0, 32'd1);

    run_op("beq", 1'b1, 6'd4, 6'd0, 32'd11, 32'd11, 32'd0, 1'b1);
    chk("beq_cnt1", cnt1, 32'd1);
    chk("beq_cnt0", cnt0, 32'd1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 6'd0, 6'd33, 32'd23, 32'd34);
    set_req(1'b1, 6'd0, 6'd35, 32'd1000, 32'd20);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_r0", req0_ready, (k % 2) == 0);
      chk("cont_r1", req1_ready, (k % 2) == 1);
      @(negedge clk);
      chk("cont_exec_r0", req0_ready, 1'b0);
      @(negedge clk);
      chk("cont_id", rsp_id, (k % 2) == 1);
      chk("cont_out", rsp_out, (k % 2) == 1 ? 32'd980 : 32'd57);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_cnt0", cnt0, 32'd2);
    chk("cont_cnt1", cnt1, 32'd2);

    rsp_ready = 1'b0;
    set_req(1'b0, 6'd0, 6'd37, 32'd44, 32'd23);
    #1;
    chk("bp_ready", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_vld", rsp_valid, 1'b1);
      chk("bp_out", rsp_out, 32'd63);
      chk("bp_r0", req0_ready, 1'b0);
      chk("bp_r1", req1_ready, 1'b0);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("bp_cnt0_hold", cnt0, 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", rsp_valid, 1'b0);
    chk("bp_cnt0", cnt0, 32'd3);

    set_req(1'b1, 6'd0, 6'd33, 32'd5, 32'd6);
    @(negedge clk);
    req1_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rx_busy", busy, 1'b0);
    chk("rx_vld", rsp_valid, 1'b0);
    chk("rx_in1", alu_in1, 32'd0);
    chk("rx_cnt1", cnt1, 32'd0);
    set_req(1'b0, 6'd0, 6'd33, 32'd7, 32'd8);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("rr_vld", rsp_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rr_vld0", rsp_valid, 1'b0);
    chk("rr_op", alu_OpCode, 32'd0);
    chk("rr_in2", alu_in2, 32'd0);
    chk("rr_cnt0", cnt0, 32'd0);
    set_req(1'b0, 6'd0, 6'd33, 32'd1, 32'd2);
    set_req(1'b1, 6'd0, 6'd33, 32'd3, 32'd4);
    #1;
    chk("rr_g0", req0_ready, 1'b1);
    chk("rr_g1", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      run_op("sat", 1'b0, 6'd0, 6'd36, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
      chk("sat_cnt0", d2_cnt0, (k > 3) ? 32'd3 : k);
      chk("wide_cnt0", cnt0, k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
